dmem_responder: RTL and testbench

//  Memory-side responder for the 16-bit RISC processor's load/store port.

---
 rtl/dmem_defs_pkg.sv | 14 +
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_defs_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings,
// the default data width and the value returned on error/write responses.
package dmem_defs;

  localparam int DATA_W_DEF = 16;
  localparam logic [DATA_W_DEF-1:0] ERR_RDATA = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store memory responder: one request at a time, fixed wait states,
// then a read-data or write-acknowledge response held until accepted.
module dmem_responder
  import dmem_defs::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              acc_we_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_wdata_s;
  logic              in_range_s;
  logic              enter_resp_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // With zero wait states the access happens on the accept edge, so take
  // the live request fields while IDLE and the latched ones otherwise.
  assign acc_we_s     = (state_q == ST_IDLE) ? req_we    : we_q;
  assign acc_addr_s   = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata_s  = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign in_range_s   = (32'(acc_addr_s) < 32'(DEPTH));
  assign enter_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign mem_we_s     = enter_resp_s && acc_we_s && in_range_s;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .addr_i  (acc_addr_s[IDX_W-1:0]),
    .wdata_i (acc_wdata_s),
    .rdata_o (mem_rdata_s)
  );

  // Next-state, wait counter and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response registers: loaded on entry to RESP, held until retired
  always_comb begin
    rsp_valid_d = (state_d == ST_RESP);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (enter_resp_s) begin
      rsp_err_d   = !in_range_s;
      rsp_rdata_d = (in_range_s && !acc_we_s) ? mem_rdata_s : DATA_W'(ERR_RDATA);
    end else if (state_d == ST_IDLE) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = DATA_W'(ERR_RDATA);
    end else begin
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  // State and response storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with 2 wait states, one with none.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  int          n_checks = 0;
  int          n_pass   = 0;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request on instance A from idle; lat counts edges until rsp_valid.
  task automatic a_xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rd, output logic err, output int lat);
    a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    a_req_valid = 1'b1; a_rsp_ready = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    a_req_valid = 1'b0;
    while (!a_rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = a_rsp_rdata; err = a_rsp_err;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
  endtask

  task automatic b_xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rd, output logic err, output int lat);
    b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
    b_req_valid = 1'b1; b_rsp_ready = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    b_req_valid = 1'b0;
    while (!b_rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = b_rsp_rdata; err = b_rsp_err;
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
  endtask

  logic [15:0] rd;
  logic        err;
  int          lat;
  logic [15:0] exp_q [3] = '{16'hA0A0, 16'hB1B1, 16'hC2C2};

  initial begin
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 16'h0000; a_req_wdata = 16'h0000; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 16'h0000; b_req_wdata = 16'h0000; b_rsp_ready = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    check("rst rsp_err",   32'(a_rsp_err),   32'd0);
    check("rst busy",      32'(a_busy),      32'd0);
    check("rst req_ready", 32'(a_req_ready), 32'd1);
    check("rst b valid",   32'(b_rsp_valid), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Basic write then read
    a_xact(1'b1, 16'd5, 16'h1234, rd, err, lat);
    check("wr5 latency", 32'(lat), 32'd3);
    check("wr5 err",     32'(err), 32'd0);
    check("wr5 rdata",   32'(rd),  32'd0);
    a_xact(1'b0, 16'd5, 16'h0000, rd, err, lat);
    check("rd5 latency", 32'(lat), 32'd3);
    check("rd5 rdata",   32'(rd),  32'h1234);
    check("rd5 err",     32'(err), 32'd0);

    // Out-of-range accesses must not alias onto low addresses
    a_xact(1'b1, 16'd44, 16'h0044, rd, err, lat);
    a_xact(1'b0, 16'd300, 16'h0000, rd, err, lat);
    check("rd300 err",     32'(err), 32'd1);
    check("rd300 rdata",   32'(rd),  32'd0);
    check("rd300 latency", 32'(lat), 32'd3);
    a_xact(1'b1, 16'd300, 16'hDEAD, rd, err, lat);
    check("wr300 err",   32'(err), 32'd1);
    check("wr300 rdata", 32'(rd),  32'd0);
    a_xact(1'b0, 16'd44, 16'h0000, rd, err, lat);
    check("rd44 rdata", 32'(rd),  32'h0044);
    check("rd44 err",   32'(err), 32'd0);
    a_xact(1'b0, 16'd256, 16'h0000, rd, err, lat);
    check("rd256 err", 32'(err), 32'd1);

    // Back-to-back reads with req_valid and rsp_ready held high
    for (int i = 0; i < 3; i++) a_xact(1'b1, 16'(10 + i), exp_q[i], rd, err, lat);
    begin
      int idx, nrsp, last;
      logic acc, hs;
      logic [15:0] cap;
      idx = 0; nrsp = 0; last = -1;
      a_req_we = 1'b0; a_req_valid = 1'b1; a_rsp_ready = 1'b1;
      for (int c = 0; c < 40 && nrsp < 3; c++) begin
        a_req_addr = 16'(10 + idx);
        acc = a_req_valid & a_req_ready;
        hs  = a_rsp_valid & a_rsp_ready;
        cap = a_rsp_rdata;
        @(posedge clk); #1;
        if (hs) begin
          check("b2b data", 32'(cap), 32'(exp_q[nrsp]));
          nrsp++;
        end
        if (acc) begin
          if (last >= 0) check("b2b spacing", 32'(c - last), 32'd4);
          last = c;
          idx++;
          if (idx == 3) a_req_valid = 1'b0;
        end
      end
      check("b2b responses", 32'(nrsp), 32'd3);
      a_req_valid = 1'b0; a_rsp_ready = 1'b0;
      @(posedge clk); #1;
    end

    // Response stall: outputs stable, second request waits for the handshake
    a_req_we = 1'b0; a_req_addr = 16'd44; a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_addr = 16'd5;
    lat = 1;
    while (!a_rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall first rdata", 32'(a_rsp_rdata), 32'h0044);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall valid",     32'(a_rsp_valid), 32'd1);
      check("stall rdata",     32'(a_rsp_rdata), 32'h0044);
      check("stall req_ready", 32'(a_req_ready), 32'd0);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check("post-hs req_ready", 32'(a_req_ready), 32'd1);
    check("post-hs busy",      32'(a_busy),      32'd0);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    check("second accepted", 32'(a_busy), 32'd1);
    lat = 1;
    while (!a_rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("second rdata", 32'(a_rsp_rdata), 32'h1234);
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;

    // Reset during WAIT drops an uncommitted write
    a_xact(1'b1, 16'd7, 16'h5555, rd, err, lat);
    a_req_we = 1'b1; a_req_addr = 16'd7; a_req_wdata = 16'hBEEF; a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    check("in WAIT busy", 32'(a_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid-rst busy",      32'(a_busy),      32'd0);
    check("mid-rst rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rel req_ready", 32'(a_req_ready), 32'd1);
    a_xact(1'b0, 16'd7, 16'h0000, rd, err, lat);
    check("rd7 old value", 32'(rd), 32'h5555);

    // Reset during RESP discards the pending response
    a_req_we = 1'b0; a_req_addr = 16'd5; a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("pre-rst rsp_valid", 32'(a_rsp_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("rsp-rst valid", 32'(a_rsp_valid), 32'd0);
    check("rsp-rst rdata", 32'(a_rsp_rdata), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Zero-wait-state build at the top address
    b_xact(1'b1, 16'd255, 16'h7E57, rd, err, lat);
    check("b wr255 latency", 32'(lat), 32'd1);
    check("b wr255 err",     32'(err), 32'd0);
    b_xact(1'b0, 16'd255, 16'h0000, rd, err, lat);
    check("b rd255 latency", 32'(lat), 32'd1);
    check("b rd255 rdata",   32'(rd),  32'h7E57);
    b_xact(1'b0, 16'd256, 16'h0000, rd, err, lat);
    check("b rd256 err",   32'(err), 32'd1);
    check("b rd256 rdata", 32'(rd),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
